button_debouncer_multi: RTL and testbench

//   N-channel push-button conditioner. This is the successor to the single-button

---
 rtl/button_debouncer_multi.sv | 112 +++++++++++
 tb/tb_button_debouncer_multi.sv | 136 +++++++++++++
 2 files changed

// File: rtl/button_debouncer_multi.sv
// rtl/button_debouncer_multi.sv - N-channel button synchroniser, debounce filter, edge pulses, long-press and auto-repeat
module button_debouncer_multi #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYC      = 5_000_000,
  parameter int HOLD_CYC    = 100_000_000,
  parameter int RPT_CYC     = 20_000_000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_CH-1:0] bt_in_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] long_press_o,
  output logic [N_CH-1:0] repeat_tick_o
);

  localparam int DBW  = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam int HMAX = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
  localparam int HW   = $clog2(HMAX + 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} hold_state_e;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DBW-1:0]         db_cnt_q, db_cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, release_q, long_q, rpt_q;
    logic [HW-1:0]          hold_cnt_q;
    hold_state_e            state_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
      level_d  = level_q;
      db_cnt_d = '0;
      if (s != level_q) begin
        if (db_cnt_q == DBW'(DB_CYC - 1)) level_d = ~level_q;
        else                              db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    // The hold FSM looks at level_d so a release on the same edge suppresses any pulse.
    // In HOLD a zero counter marks "long_press already fired" when repeat is disabled.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        sync_q     <= '0;
        db_cnt_q   <= '0;
        level_q    <= 1'b0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        long_q     <= 1'b0;
        rpt_q      <= 1'b0;
        hold_cnt_q <= '0;
        state_q    <= IDLE;
      end else begin
        sync_q    <= {sync_q[SYNC_STAGES-2:0], bt_in_i[i]};
        db_cnt_q  <= db_cnt_d;
        level_q   <= level_d;
        press_q   <= level_d & ~level_q;
        release_q <= ~level_d & level_q;
        long_q    <= 1'b0;
        rpt_q     <= 1'b0;
        if (!level_d) begin
          state_q    <= IDLE;
          hold_cnt_q <= '0;
        end else begin
          case (state_q)
            IDLE: begin
              if (press_q) begin
                state_q    <= HOLD;
                hold_cnt_q <= HW'(1);
              end
            end
            HOLD: begin
              if (hold_cnt_q != '0) begin
                if (hold_cnt_q == HW'(HOLD_CYC - 1)) begin
                  long_q     <= 1'b1;
                  hold_cnt_q <= '0;
                  if (RPT_CYC > 0) state_q <= REPEAT;
                end else begin
                  hold_cnt_q <= hold_cnt_q + 1'b1;
                end
              end
            end
            REPEAT: begin
              if (hold_cnt_q == HW'(RPT_CYC - 1)) begin
                rpt_q      <= 1'b1;
                hold_cnt_q <= '0;
              end else begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
              end
            end
            default: begin
              state_q    <= IDLE;
              hold_cnt_q <= '0;
            end
          endcase
        end
      end
    end

    assign level_o[i]       = level_q;
    assign press_o[i]       = press_q;
    assign release_o[i]     = release_q;
    assign long_press_o[i]  = long_q;
    assign repeat_tick_o[i] = rpt_q;
  end

endmodule

// File: tb/tb_button_debouncer_multi.sv
// tb/tb_button_debouncer_multi.sv - directed bench for button_debouncer_multi, repeat enabled and disabled
module tb_button_debouncer_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] bt  = 2'b00;

  logic [1:0] lvl_a, prs_a, rel_a, lp_a, rt_a;
  logic [1:0] lvl_b, prs_b, rel_b, lp_b, rt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_debouncer_multi #(
    .N_CH(2), .SYNC_STAGES(2), .DB_CYC(4), .HOLD_CYC(10), .RPT_CYC(3)
  ) u_dut_rpt (
    .clk_i(clk), .rst_i(rst), .bt_in_i(bt),
    .level_o(lvl_a), .press_o(prs_a), .release_o(rel_a),
    .long_press_o(lp_a), .repeat_tick_o(rt_a)
  );

  button_debouncer_multi #(
    .N_CH(2), .SYNC_STAGES(2), .DB_CYC(4), .HOLD_CYC(10), .RPT_CYC(0)
  ) u_dut_norpt (
    .clk_i(clk), .rst_i(rst), .bt_in_i(bt),
    .level_o(lvl_b), .press_o(prs_b), .release_o(rel_b),
    .long_press_o(lp_b), .repeat_tick_o(rt_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed as {level, press, release, long_press, repeat_tick}
  function automatic logic [4:0] obs_a(input int ch);
    return {lvl_a[ch], prs_a[ch], rel_a[ch], lp_a[ch], rt_a[ch]};
  endfunction

  function automatic logic [4:0] obs_b(input int ch);
    return {lvl_b[ch], prs_b[ch], rel_b[ch], lp_b[ch], rt_b[ch]};
  endfunction

  function automatic logic [4:0] pack(input bit l, input bit p, input bit r, input bit lg, input bit rp);
    return {l, p, r, lg, rp};
  endfunction

  initial begin
    repeat (3) tick();
    check("reset ch0 rpt",   32'(obs_a(0)), 32'h0);
    check("reset ch1 rpt",   32'(obs_a(1)), 32'h0);
    check("reset ch0 norpt", 32'(obs_b(0)), 32'h0);
    check("reset ch1 norpt", 32'(obs_b(1)), 32'h0);
    rst = 1'b0;
    repeat (3) tick();

    // Press, hold through long-press and repeats, release sampled at edge 27
    bt = 2'b01;
    for (int e = 1; e <= 40; e++) begin
      tick();
      check($sformatf("hold rpt e%0d", e), 32'(obs_a(0)),
            32'(pack(e >= 6 && e < 32, e == 6, e == 32, e == 16,
                     e >= 19 && e < 32 && (e - 19) % 3 == 0)));
      check($sformatf("hold norpt e%0d", e), 32'(obs_b(0)),
            32'(pack(e >= 6 && e < 32, e == 6, e == 32, e == 16, 1'b0)));
      if (e == 26) bt = 2'b00;
    end
    check("hold ch1 idle", 32'(obs_a(1)), 32'h0);

    // Short glitch, then a 3-on/1-off bounce train
    bt = 2'b01;
    repeat (3) tick();
    bt = 2'b00;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("glitch e%0d", e), 32'(obs_a(0)), 32'h0);
    end
    for (int k = 0; k < 3; k++) begin
      bt = 2'b01;
      repeat (3) tick();
      bt = 2'b00;
      tick();
      check($sformatf("bounce k%0d", k), 32'(obs_a(0)), 32'h0);
    end

    // Short press: bt back to 0 sampled at edge 9
    bt = 2'b01;
    for (int e = 1; e <= 20; e++) begin
      tick();
      check($sformatf("short rpt e%0d", e), 32'(obs_a(0)),
            32'(pack(e >= 6 && e < 14, e == 6, e == 14, 1'b0, 1'b0)));
      check($sformatf("short norpt e%0d", e), 32'(obs_b(0)),
            32'(pack(e >= 6 && e < 14, e == 6, e == 14, 1'b0, 1'b0)));
      if (e == 8) bt = 2'b00;
    end

    // Both channels pressed together
    bt = 2'b11;
    for (int e = 1; e <= 17; e++) begin
      tick();
      check($sformatf("dual press e%0d", e), 32'(prs_a), (e == 6) ? 32'h3 : 32'h0);
      check($sformatf("dual long e%0d", e), 32'(lp_a), (e == 16) ? 32'h3 : 32'h0);
    end
    bt = 2'b00;
    repeat (8) tick();
    check("dual released", 32'(lvl_a), 32'h0);

    // Reset sampled at edge 4 of a debounce with the button held
    bt = 2'b01;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid reset rpt",   32'({lvl_a, prs_a, rel_a, lp_a, rt_a}), 32'h0);
    check("mid reset norpt", 32'({lvl_b, prs_b, rel_b, lp_b, rt_b}), 32'h0);
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("after reset e%0d", e), 32'(obs_a(0)),
            32'(pack(e >= 6, e == 6, 1'b0, 1'b0, 1'b0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
